// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected ReLU layer.
package fc_pkg;

  // Sequencer states: wait for operands, accumulate columns, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fc_state_t;

  // Accumulator width: full NxN product, log2(K) growth, one bit for bias headroom.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned k);
    return 2 * n + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron lane: signed NxN multiply, A-bit accumulate, load of an initial value, ReLU view.
module fc_mac_lane #(
  parameter int unsigned N = 8,
  parameter int unsigned A = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [A-1:0] i_init,
  input  logic [N-1:0] i_w,
  input  logic [N-1:0] i_x,
  output logic [A-2:0] o_relu
);

  logic signed [2*N-1:0] w_prod;
  logic signed [A-1:0]   w_prod_ext;
  logic signed [A-1:0]   r_acc;

  assign w_prod     = $signed(i_w) * $signed(i_x);
  assign w_prod_ext = {{(A - 2 * N){w_prod[2*N-1]}}, w_prod};

  // Accumulator: load takes priority over accumulate so a fresh operand set starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= $signed(i_init);
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // ReLU: negative sums clamp to zero, the sign bit is dropped from the output.
  assign o_relu = r_acc[A-1] ? '0 : r_acc[A-2:0];

endmodule

// File: rtl/fc_relu_seq.sv
// Sequential fully-connected layer with ReLU: one input column per cycle, J lanes in parallel.
// Optional bias input enabled by defining FC_RELU_SEQ_BIAS_EN.
module fc_relu_seq
  import fc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned J = 3,
  parameter int unsigned K = 3,
  localparam int unsigned A = acc_width(N, K)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [J*K*N-1:0]   g_input,
  input  logic [K*N-1:0]     e_input,
`ifdef FC_RELU_SEQ_BIAS_EN
  input  logic [J*N-1:0]     b_input,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [J*(A-1)-1:0] o
);

  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  fc_state_t          r_state;
  logic [CW-1:0]      r_cnt;
  logic [J*K*N-1:0]   r_g;
  logic [K*N-1:0]     r_e;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_mac;
  logic [N-1:0]       w_x;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_mac     = (r_state == MAC);
  assign w_x       = r_e[int'(r_cnt) * N +: N];
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  // Sequencer: capture operands, walk the columns, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_g         <= '0;
      r_e         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_g        <= g_input;
            r_e        <= e_input;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          if (r_cnt == CW'(K - 1)) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // One MAC lane per output row, all fed the same input element for the current column.
  for (genvar gj = 0; gj < J; gj++) begin : g_lane
    logic [A-1:0] w_init;
    logic [N-1:0] w_w;

`ifdef FC_RELU_SEQ_BIAS_EN
    assign w_init = {{(A - N){b_input[gj*N+N-1]}}, b_input[gj*N +: N]};
`else
    assign w_init = '0;
`endif
    assign w_w = r_g[(gj * K + int'(r_cnt)) * N +: N];

    fc_mac_lane #(
      .N(N),
      .A(A)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .i_en   (w_mac),
      .i_init (w_init),
      .i_w    (w_w),
      .i_x    (w_x),
      .o_relu (o[gj*(A-1) +: (A-1)])
    );
  end

endmodule

// File: tb/tb_fc_relu_seq.sv
// Directed self-checking bench for fc_relu_seq (N=8, J=3, K=3) plus a K=1 instance.
module tb_fc_relu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] g;
  logic [23:0] e;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [53:0] o;

  logic [23:0] g1;
  logic [7:0]  e1;
  logic        in_valid1, in_ready1, out_valid1;
  logic [47:0] o1;

`ifdef FC_RELU_SEQ_BIAS_EN
  logic [23:0] b;
  logic [23:0] b1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fc_relu_seq #(.N(8), .J(3), .K(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .g_input   (g),
    .e_input   (e),
`ifdef FC_RELU_SEQ_BIAS_EN
    .b_input   (b),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
  );

  fc_relu_seq #(.N(8), .J(3), .K(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .g_input   (g1),
    .e_input   (e1),
`ifdef FC_RELU_SEQ_BIAS_EN
    .b_input   (b1),
`endif
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .out_valid (out_valid1),
    .out_ready (1'b1),
    .o         (o1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk_g(input int a00, a01, a02, a10, a11, a12, a20, a21, a22);
    return {8'(a22), 8'(a21), 8'(a20), 8'(a12), 8'(a11), 8'(a10), 8'(a02), 8'(a01), 8'(a00)};
  endfunction

  function automatic logic [23:0] mk_e(input int x0, x1, x2);
    return {8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [53:0] mk_o(input int r0, r1, r2);
    return {18'(r2), 18'(r1), 18'(r0)};
  endfunction

  // Offer one operand set, scramble the ports after accept, wait for out_valid and check it.
  task automatic run3(input string tag, input logic [71:0] g_v, input logic [23:0] e_v,
                      input logic [53:0] exp);
    int lat;
    g = g_v;
    e = e_v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    g = 72'({$urandom(), $urandom(), $urandom()});
    e = 24'($urandom());
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'(0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(3));
    check({tag, "_o"}, 64'(o), 64'(exp));
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    g = '0; e = '0; in_valid = 1'b0; out_ready = 1'b1;
    g1 = '0; e1 = '0; in_valid1 = 1'b0;
`ifdef FC_RELU_SEQ_BIAS_EN
    b = '0; b1 = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_o", 64'(o), 64'(0));

    // Mixed-sign rows, single-cycle result with out_ready high.
    run3("basic", mk_g(1, 2, 3, -1, -2, -3, 0, 0, 0), mk_e(4, 5, 6), mk_o(32, 0, 0));
    tick();
    check("basic_valid_one_cycle", 64'(out_valid), 64'(0));
    check("basic_back_idle", 64'(in_ready), 64'(1));

    // Most negative operands everywhere, held under backpressure.
    out_ready = 1'b0;
    run3("maxneg", mk_g(-128, -128, -128, -128, -128, -128, -128, -128, -128),
         mk_e(-128, -128, -128), mk_o(49152, 49152, 49152));
    for (int i = 0; i < 5; i++) begin
      g = mk_g(1, 1, 1, 1, 1, 1, 1, 1, 1);
      e = mk_e(1, 1, 1);
      in_valid = 1'b1;
      tick();
      check("hold_o", 64'(o), 64'(mk_o(49152, 49152, 49152)));
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check("release_valid", 64'(out_valid), 64'(0));
    check("release_no_accept", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    tick();
    check("idle_stays", 64'(in_ready), 64'(1));

    // Reset on the second MAC edge discards the computation.
    g = mk_g(5, 5, 5, 5, 5, 5, 5, 5, 5);
    e = mk_e(5, 5, 5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_o", 64'(o), 64'(0));
    run3("after_rst", mk_g(2, 0, 0, 0, -1, 5, 1, 1, 1), mk_e(3, -2, 7), mk_o(6, 37, 8));
    tick();

`ifdef FC_RELU_SEQ_BIAS_EN
    b = {8'(10), 8'(-3), 8'(-4)};
    run3("bias", mk_g(1, 1, 1, 1, 1, 1, 1, 1, 1), mk_e(1, 1, 1), mk_o(0, 0, 13));
    tick();
`endif

    // Single-column instance: result one edge after accept.
    g1 = {8'(0), 8'(7), 8'(-5)};
    e1 = 8'(3);
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("k1_in_ready_low", 64'(in_ready1), 64'(0));
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    check("k1_latency", 64'(lat), 64'(1));
    check("k1_o", 64'(o1), 64'({16'd0, 16'd21, 16'd0}));
    tick();
    check("k1_back_idle", 64'(in_ready1), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
